// File: rtl/datapath_pipe.sv
// Two-stage datapath: register file with writeback forwarding, 8-op ALU with
// {Z,N,C,V} flags, conditional/relative program counter and handshaked memory port.
module datapath_pipe #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int PC_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     regwrite,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    input  logic [2:0]               aluop,
    input  logic [WIDTH-1:0]         imm,
    input  logic                     imm_sel,
    input  logic                     mem_rd,
    input  logic                     mem_wr,
    input  logic                     pc_en,
    input  logic                     ld_pc_en,
    input  logic                     pc_mux,
    input  logic [1:0]               br_cond,
    input  logic [PC_W-1:0]          pc_target,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic                     mem_ack,
    output logic [PC_W-1:0]          pc,
    output logic [WIDTH-1:0]         result,
    output logic [3:0]               flags,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    output logic                     busy
);
    localparam int RAW = $clog2(NREGS);

    typedef enum logic {S_IDLE, S_MEM} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_wb_valid;
    logic [RAW-1:0]   r_wb_addr;
    logic [WIDTH-1:0] r_wb_data;
    logic [RAW-1:0]   r_mem_wa;
    logic [PC_W-1:0]  r_pc;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;

    logic             w_busy;
    logic             w_mem_issue;
    logic             w_alu_issue;
    logic             w_mem_done;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_cond;

    assign w_busy      = (r_state == S_MEM);
    assign w_mem_issue = !w_busy && (mem_rd || mem_wr);
    assign w_alu_issue = !w_busy && !mem_rd && !mem_wr;
    assign w_mem_done  = w_busy && mem_ack;

    // The WB stage is written into the array one edge later, so it must win over the array.
    always_comb begin
        w_rd1 = r_regs[ra1];
        if (ra1 == '0)
            w_rd1 = '0;
        else if (r_wb_valid && (r_wb_addr == ra1))
            w_rd1 = r_wb_data;
        w_rd2 = r_regs[ra2];
        if (ra2 == '0)
            w_rd2 = '0;
        else if (r_wb_valid && (r_wb_addr == ra2))
            w_rd2 = r_wb_data;
    end

    assign w_b = imm_sel ? imm : w_rd2;

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (aluop)
            3'b000: begin
                w_sum = {1'b0, w_rd1} + {1'b0, w_b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_rd1[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_rd1[WIDTH-1]);
            end
            3'b001: begin
                w_sum = {1'b0, w_rd1} + {1'b0, ~w_b} + (WIDTH+1)'(1);
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_rd1[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_rd1[WIDTH-1]);
            end
            3'b010: w_res = w_rd1 & w_b;
            3'b011: w_res = w_rd1 | w_b;
            3'b100: w_res = w_rd1 ^ w_b;
            3'b101: begin
                w_res = {w_rd1[WIDTH-2:0], 1'b0};
                w_c   = w_rd1[WIDTH-1];
            end
            3'b110: begin
                w_res = {1'b0, w_rd1[WIDTH-1:1]};
                w_c   = w_rd1[0];
            end
            default: w_res = w_b;
        endcase
    end

    always_comb begin
        case (br_cond)
            2'b00:   w_cond = 1'b1;
            2'b01:   w_cond = r_flags[3];
            2'b10:   w_cond = r_flags[2];
            default: w_cond = !r_flags[3];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            if (r_wb_valid && (r_wb_addr != '0))
                r_regs[r_wb_addr] <= r_wb_data;
            r_wb_valid <= 1'b0;
            if (w_alu_issue && regwrite) begin
                r_wb_valid <= 1'b1;
                r_wb_addr  <= wa;
                r_wb_data  <= w_res;
            end else if (w_mem_done && !r_mem_we) begin
                r_wb_valid <= 1'b1;
                r_wb_addr  <= r_mem_wa;
                r_wb_data  <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (!w_busy) begin
            if (ld_pc_en && w_cond)
                r_pc <= pc_mux ? (r_pc + pc_target) : pc_target;
            else if (pc_en)
                r_pc <= r_pc + PC_W'(1);
            if (w_alu_issue) begin
                r_result <= w_res;
                r_flags  <= {(w_res == '0), w_res[WIDTH-1], w_c, w_v};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wa    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_mem_issue) begin
                    r_state     <= S_MEM;
                    r_mem_we    <= mem_wr;
                    r_mem_addr  <= w_rd1;
                    r_mem_wdata <= w_rd2;
                    r_mem_wa    <= wa;
                end
                default: if (mem_ack) begin
                    r_state  <= S_IDLE;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign result    = r_result;
    assign flags     = r_flags;
    assign busy      = w_busy;
    assign mem_req   = w_busy;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
